// File: rtl/kamikaze_execute_pipe.sv
// rtl/kamikaze_execute_pipe.sv - RV32I execute stage with registered valid/ready output and flush
// Define KAMIKAZE_EXEC_MUL_EN to add the iterative shift-add multiplier on func 10.
module kamikaze_execute_pipe #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [XLEN-1:0]      alu_op1_i,
  input  logic [XLEN-1:0]      alu_op2_i,
  input  logic [3:0]           alu_func_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [RF_ADDR_W-1:0] rf_rd_i,
  input  logic                 rf_rd_we_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [RF_ADDR_W-1:0] rf_rd_o,
  output logic                 rf_rd_we_o,
  output logic                 busy_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLL  = 4'd2;
  localparam logic [3:0] F_SLT  = 4'd3;
  localparam logic [3:0] F_SLTU = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_OR   = 4'd8;
  localparam logic [3:0] F_AND  = 4'd9;

  logic                 accept;
  logic                 idle;
  logic                 is_mul;
  logic                 mul_done;
  logic [SHW-1:0]       shamt;
  logic [XLEN-1:0]      alu_res;
  logic [XLEN-1:0]      mul_res;
  logic [XLEN-1:0]      mul_pc;
  logic [RF_ADDR_W-1:0] mul_rd;
  logic                 mul_we;

  logic                 valid_q,  valid_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [XLEN-1:0]      pc_q,     pc_d;
  logic [RF_ADDR_W-1:0] rd_q,     rd_d;
  logic                 we_q,     we_d;

  assign shamt = alu_op2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_func_i)
      F_ADD:   alu_res = alu_op1_i + alu_op2_i;
      F_SUB:   alu_res = alu_op1_i - alu_op2_i;
      F_SLL:   alu_res = alu_op1_i << shamt;
      F_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_op1_i) < $signed(alu_op2_i))};
      F_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (alu_op1_i < alu_op2_i)};
      F_XOR:   alu_res = alu_op1_i ^ alu_op2_i;
      F_SRL:   alu_res = alu_op1_i >> shamt;
      F_SRA:   alu_res = $unsigned($signed(alu_op1_i) >>> shamt);
      F_OR:    alu_res = alu_op1_i | alu_op2_i;
      F_AND:   alu_res = alu_op1_i & alu_op2_i;
      default: alu_res = '0;
    endcase
  end

`ifdef KAMIKAZE_EXEC_MUL_EN
  localparam logic [3:0] F_MUL  = 4'd10;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]           state_q,  state_d;
  logic [SHW-1:0]       cnt_q,    cnt_d;
  logic [XLEN-1:0]      mcand_q,  mcand_d;
  logic [XLEN-1:0]      mplier_q, mplier_d;
  logic [XLEN-1:0]      prod_q,   prod_d;
  logic [XLEN-1:0]      mpc_q,    mpc_d;
  logic [RF_ADDR_W-1:0] mrd_q,    mrd_d;
  logic                 mwe_q,    mwe_d;
  logic [XLEN-1:0]      prod_step;

  // One multiplier bit per cycle; the last step feeds the output registers directly.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign idle      = (state_q == S_IDLE);
  assign is_mul    = (alu_func_i == F_MUL);
  assign mul_done  = (state_q == S_MUL) && (&cnt_q);
  assign busy_o    = (state_q == S_MUL);
  assign mul_res   = prod_step;
  assign mul_pc    = mpc_q;
  assign mul_rd    = mrd_q;
  assign mul_we    = mwe_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    mpc_d    = mpc_q;
    mrd_d    = mrd_q;
    mwe_d    = mwe_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept && is_mul) begin
      state_d  = S_MUL;
      cnt_d    = '0;
      mcand_d  = alu_op1_i;
      mplier_d = alu_op2_i;
      prod_d   = '0;
      mpc_d    = pc_i;
      mrd_d    = rf_rd_i;
      mwe_d    = rf_rd_we_i;
    end else if (state_q == S_MUL) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      mpc_q    <= '0;
      mrd_q    <= '0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      mpc_q    <= mpc_d;
      mrd_q    <= mrd_d;
      mwe_q    <= mwe_d;
    end
  end
`else
  assign idle     = 1'b1;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign busy_o   = 1'b0;
  assign mul_res  = '0;
  assign mul_pc   = '0;
  assign mul_rd   = '0;
  assign mul_we   = 1'b0;
`endif

  assign ready_o = idle && (!valid_q || ready_i) && !flush_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    pc_d     = pc_q;
    rd_d     = rd_q;
    we_d     = we_q;
    if (flush_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (accept && !is_mul) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      pc_d     = pc_i;
      rd_d     = rf_rd_i;
      we_d     = rf_rd_we_i;
    end else if (mul_done) begin
      valid_d  = 1'b1;
      result_d = mul_res;
      pc_d     = mul_pc;
      rd_d     = mul_rd;
      we_d     = mul_we;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
    end
  end

  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign pc_o       = pc_q;
  assign rf_rd_o    = rd_q;
  assign rf_rd_we_o = we_q && valid_q;

endmodule

// File: tb/tb_kamikaze_execute_pipe.sv
// tb/tb_kamikaze_execute_pipe.sv - randomized scoreboard bench for kamikaze_execute_pipe
module tb_kamikaze_execute_pipe;
  localparam int XLEN = 32;
  localparam int RFW  = 5;
`ifdef KAMIKAZE_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] alu_op1_i;
  logic [XLEN-1:0] alu_op2_i;
  logic [3:0]      alu_func_i;
  logic [XLEN-1:0] pc_i;
  logic [RFW-1:0]  rf_rd_i;
  logic            rf_rd_we_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic [XLEN-1:0] pc_o;
  logic [RFW-1:0]  rf_rd_o;
  logic            rf_rd_we_o;
  logic            busy_o;

  always #5 clk_i = ~clk_i;

  kamikaze_execute_pipe #(.XLEN(XLEN), .RF_ADDR_W(RFW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op1_i(alu_op1_i), .alu_op2_i(alu_op2_i), .alu_func_i(alu_func_i),
    .pc_i(pc_i), .rf_rd_i(rf_rd_i), .rf_rd_we_i(rf_rd_we_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .pc_o(pc_o),
    .rf_rd_o(rf_rd_o), .rf_rd_we_o(rf_rd_we_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] pc;
    logic [RFW-1:0]  rd;
    logic            we;
    int              t;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int unsigned sh;
    logic [2*XLEN-1:0] p;
    sh = b % XLEN;
    p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
      4'd4:  return (a < b) ? XLEN'(1) : XLEN'(0);
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return a[XLEN-1] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return MUL_EN ? p[XLEN-1:0] : XLEN'(0);
      default: return XLEN'(0);
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] f);
    return (MUL_EN && f == 4'd10) ? XLEN + 1 : 1;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(XLEN-1){1'b0}}};
      3:       return XLEN'($urandom_range(0, 40));
      default: return XLEN'($urandom());
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: model valid/busy/ready from queued expectations and their ages.
  always @(negedge clk_i) begin : mon
    logic exp_valid, exp_busy, exp_ready;
    int   age;
    cyc++;
    if (!rst_i) begin
      sb.delete();
    end else begin
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      if (sb.size() > 0) begin
        age       = cyc - sb[0].t;
        exp_valid = (age >= sb[0].lat);
        exp_busy  = (sb[0].lat > 1) && (age < sb[0].lat);
      end
      exp_ready = !exp_busy && (!exp_valid || ready_i) && !flush_i;
      chk("valid_o", valid_o, exp_valid);
      chk("busy_o", busy_o, exp_busy);
      chk("ready_o", ready_o, exp_ready);
      if (exp_valid) begin
        chk("result_o", result_o, sb[0].res);
        chk("pc_o", pc_o, sb[0].pc);
        chk("rf_rd_o", rf_rd_o, sb[0].rd);
        chk("rf_rd_we_o", rf_rd_we_o, sb[0].we);
      end else begin
        chk("rf_rd_we_o_idle", rf_rd_we_o, 0);
      end
      if (flush_i) begin
        sb.delete();
      end else begin
        if (exp_valid && ready_i) void'(sb.pop_front());
        if (valid_i && exp_ready) begin
          sb.push_back('{res: ref_alu(alu_func_i, alu_op1_i, alu_op2_i), pc: pc_i,
                         rd: rf_rd_i, we: rf_rd_we_i, t: cyc, lat: lat_of(alu_func_i)});
          n_acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [3:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [RFW-1:0] rd, input logic we);
    int start;
    int k;
    alu_func_i = f;
    alu_op1_i  = a;
    alu_op2_i  = b;
    rf_rd_i    = rd;
    rf_rd_we_i = we;
    pc_i       = XLEN'($urandom());
    valid_i    = 1'b1;
    start      = n_acc;
    k          = 0;
    while (n_acc == start && k < 100) begin
      step();
      k++;
    end
    chk("send_accepted", n_acc != start, 1);
    valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_o"}, valid_o, 0);
    chk({tag, "_result_o"}, result_o, 0);
    chk({tag, "_pc_o"}, pc_o, 0);
    chk({tag, "_rf_rd_o"}, rf_rd_o, 0);
    chk({tag, "_rf_rd_we_o"}, rf_rd_we_o, 0);
    chk({tag, "_busy_o"}, busy_o, 0);
    chk({tag, "_ready_o"}, ready_o, 1);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    flush_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 check_reset_outputs("midrst");
    step();
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    alu_op1_i = '0; alu_op2_i = '0; alu_func_i = '0; pc_i = '0; rf_rd_i = '0; rf_rd_we_i = 1'b0;
    #1 rst_i = 1'b0;
    #1 check_reset_outputs("rst");
    step();
    step();
    rst_i = 1'b1;
    step();

    send(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd1, 1'b1);
    send(4'd1, 32'd5, 32'd7, 5'd2, 1'b1);
    send(4'd7, 32'h8000_0000, 32'h24, 5'd3, 1'b1);
    send(4'd6, 32'h8000_0000, 32'h24, 5'd4, 1'b1);
    send(4'd3, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1);
    send(4'd4, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b0);
    send(4'd2, 32'h0000_0003, 32'h3F, 5'd7, 1'b1);
    send(4'd15, 32'h1234_5678, 32'h1, 5'd8, 1'b1);
    send(4'd10, 32'd3, 32'd4, 5'd9, 1'b1);
    repeat (XLEN + 3) step();

    ready_i = 1'b0;
    send(4'd0, 32'd10, 32'd20, 5'd10, 1'b1);
    alu_func_i = 4'd5; alu_op1_i = 32'hF0F0_F0F0; alu_op2_i = 32'h0FF0_0FF0; valid_i = 1'b1;
    repeat (3) step();
    ready_i = 1'b1;
    send(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11, 1'b1);
    step();

    ready_i = 1'b0;
    send(4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd5, 1'b1);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) step();

`ifdef KAMIKAZE_EXEC_MUL_EN
    send(4'd10, 32'd7, 32'd6, 5'd12, 1'b1);
    repeat (XLEN + 3) step();
    send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1);
    repeat (XLEN + 3) step();
    send(4'd10, 32'd123, 32'd456, 5'd14, 1'b1);
    repeat (9) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (XLEN + 3) step();
    send(4'd10, 32'd99, 32'd77, 5'd15, 1'b1);
    repeat (5) step();
    do_reset();
    send(4'd0, 32'd1, 32'd2, 5'd16, 1'b1);
    repeat (2) step();
`endif

    for (int i = 0; i < 600; i++) begin
      valid_i    = ($urandom_range(0, 3) != 0);
      ready_i    = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 39) == 0);
      alu_func_i = 4'($urandom_range(0, 15));
      alu_op1_i  = pick();
      alu_op2_i  = pick();
      pc_i       = XLEN'($urandom());
      rf_rd_i    = RFW'($urandom());
      rf_rd_we_i = 1'($urandom_range(0, 1));
      if (i == 300) begin
        do_reset();
        send(4'd1, 32'd0, 32'd1, 5'd17, 1'b1);
      end else begin
        step();
      end
    end

    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < XLEN + 10 && sb.size() > 0; k++) step();
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
